alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Program sequencer for the 8-bit ALU datapath. On start it walks a program:
//  fetches an opcode from the opcode ROM and one or two operands from the data ROM,
//  presents them to alu8, captures the result and pulses result_valid.
//  It sits between the two sync ROMs and alu8, and replaces the ad-hoc controller.
// PARAMETERS
//  ADDR_W  4  ROM address width; all address arithmetic is mod 2**ADDR_W
//  DATA_W  8  operand/result/opcode width
// PORTS
//  clk           in   1       system clock, rising edge; the only clock
//  rst           in   1       asynchronous, active-high reset
//  start         in   1       1-cycle request to run a program; ignored while busy
//  prog_len      in   ADDR_W  instruction count, sampled on accepted start
//  op_addr       out  ADDR_W  opcode ROM address
//  op_data       in   DATA_W  opcode ROM data, valid 1 clk after op_addr
//  data_addr     out  ADDR_W  data ROM address
//  data_in       in   DATA_W  data ROM data, valid 1 clk after data_addr
//  alu_in1       out  DATA_W  ALU operand A
//  alu_in2       out  DATA_W  ALU operand B
//  alu_opcode    out  DATA_W  ALU opcode
//  alu_result    in   DATA_W  combinational ALU result
//  result        out  DATA_W  last captured ALU result
//  result_valid  out  1       1-cycle pulse when result updates
//  busy          out  1       high from accepted start until done
//  done          out  1       1-cycle pulse at program end
//  err           out  1       sticky illegal-opcode flag; cleared on accepted start
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0; pc=0.
//  - States: IDLE, F_OP, F_A, F_B, EXEC, WB, FIN. All registered, Moore outputs.
//  - IDLE: start=1 -> latch prog_len, pc=0, clear err, busy=1.
//    prog_len=0 -> FIN; otherwise -> F_OP.
//  - F_OP: op_addr=pc -> F_A.
//  - F_A: latch op_data as op. op=0 (HALT) -> FIN. op>7 -> set err, skip to next.
//    Otherwise data_addr=2*pc -> F_B.
//  - F_B: latch A. Unary op (5,6): B=0, -> EXEC.
//    Otherwise data_addr=2*pc+1 and wait 1 clk, then latch B -> EXEC.
//  - EXEC: drive alu_in1=A, alu_in2=B, alu_opcode=op -> WB.
//  - WB: result<=alu_result, result_valid=1 -> next.
//  - Next: pc+1==prog_len -> FIN; else pc++ -> F_OP.
//  - FIN: done=1, busy=0 -> IDLE.
//  - Latency per binary instruction: 6 clks from F_OP entry to result_valid.
//    Unary instruction: 5 clks.
//  - alu_opcode is 8'h00 in every state except EXEC/WB, so back-to-back
//    identical opcodes still change the ALU's opcode input and retrigger it.
//  - alu_in1/alu_in2 hold their values between instructions.
//  - Data addresses wrap mod 2**ADDR_W (pc>=8 with ADDR_W=4 reuses data).
//  - start during busy: ignored, no effect on prog_len or err.
//  - rst mid-program: immediate IDLE, no done or result_valid pulse.
// CONFIGURATION
//  ALU_SEQ_CHAIN_EN defined: for pc>0, A = previous result and the F_B data fetch
//    is skipped; B comes from data_addr=2*pc+1. Unary ops with pc>0 fetch nothing.
//    Binary instruction latency drops to 5 clks.
//  Undefined: every instruction fetches its own operands as described above.
// TESTING (op ROM 01,05,07,04,02,06,03; data ROM 26,c7,9c,8c,bc,7e,...)
//  - rst pulse mid-F_B -> all outputs 0 in the same cycle; next start runs from pc=0.
//  - start, prog_len=1 -> result=8'hED (26+c7), one result_valid, then done;
//    busy high for 8 clks.
//  - start, prog_len=3 -> results ED, 63 (~9c, unary), 00 (bc<7e false);
//    exactly 3 result_valid pulses, then done.
//  - op ROM word 2 = 8'h09, prog_len=3 -> err=1, only 2 result_valid pulses.
//    err stays high until next start.
//  - start, prog_len=0 -> done 1 clk later, no result_valid.
//    Extra start pulses while busy are ignored.
//  - ALU_SEQ_CHAIN_EN, prog_len=2 -> results ED, then ~ED=8'h12; no fetch at data_addr 2.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: walks a program held in two synchronous ROMs (opcode ROM and
// data ROM), feeds each instruction's operands to the external alu8 and
// captures its result.
// Optional feature macro: ALU_SEQ_CHAIN_EN. When defined, every instruction
// after the first uses the previous result as operand A instead of fetching it.
//
// state | meaning
// IDLE  | waiting for start
// F_OP  | opcode address on op_addr, ROM read in flight
// F_A   | opcode arrives: decode halt / illegal / operand fetch
// F_B   | operand fetch sub-steps (fb_step), ends by loading the ALU inputs
// EXEC  | ALU inputs and opcode stable, result captured at the end
// WB    | result_valid pulse, advance pc or finish
// FIN   | done pulse, busy still high for this last cycle
module alu_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_len,
  output logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_data,
  output logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [DATA_W-1:0] alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, F_OP, F_A, F_B, EXEC, WB, FIN} state_t;

  // F_B sub-steps. The second operand address is issued as soon as the first
  // is in flight so a binary fetch costs three cycles, not four.
  localparam logic [1:0] FB_WAIT_A  = 2'd0;
  localparam logic [1:0] FB_LATCH_A = 2'd1;
  localparam logic [1:0] FB_LATCH_B = 2'd2;
  localparam logic [1:0] FB_WAIT_B  = 2'd3;

  state_t            state;
  logic [1:0]        fb_step;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] len;
  logic [DATA_W-1:0] op;
  logic [DATA_W-1:0] opnd_a;
  logic [ADDR_W-1:0] pc_next;
  logic              last_instr;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;

  function automatic logic is_unary(input logic [DATA_W-1:0] o);
    return (o == DATA_W'(5)) || (o == DATA_W'(6));
  endfunction

  // Next-pc and operand addresses; doubling drops the pc MSB so addresses wrap.
  always_comb begin
    pc_next    = pc + 1'b1;
    last_instr = (pc_next == len);
    addr_a     = {pc[ADDR_W-2:0], 1'b0};
    addr_b     = {pc[ADDR_W-2:0], 1'b1};
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      fb_step      <= FB_WAIT_A;
      pc           <= '0;
      len          <= '0;
      op           <= '0;
      opnd_a       <= '0;
      op_addr      <= '0;
      data_addr    <= '0;
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_opcode   <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len     <= prog_len;
            pc      <= '0;
            op_addr <= '0;
            err     <= 1'b0;
            busy    <= 1'b1;
            if (prog_len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= F_OP;
            end
          end
        end
        F_OP: state <= F_A;
        F_A: begin
          op <= op_data;
          if (op_data == '0) begin
            state <= FIN;
            done  <= 1'b1;
          end else if (op_data > DATA_W'(7)) begin
            err <= 1'b1;
            if (last_instr) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              pc      <= pc_next;
              op_addr <= pc_next;
              state   <= F_OP;
            end
          end else begin
`ifdef ALU_SEQ_CHAIN_EN
            if (pc != '0) begin
              opnd_a <= result;
              if (is_unary(op_data)) begin
                alu_in1    <= result;
                alu_in2    <= '0;
                alu_opcode <= op_data;
                state      <= EXEC;
              end else begin
                data_addr <= addr_b;
                fb_step   <= FB_WAIT_B;
                state     <= F_B;
              end
            end else begin
              data_addr <= addr_a;
              fb_step   <= FB_WAIT_A;
              state     <= F_B;
            end
`else
            data_addr <= addr_a;
            fb_step   <= FB_WAIT_A;
            state     <= F_B;
`endif
          end
        end
        F_B: begin
          case (fb_step)
            FB_WAIT_A: begin
              if (!is_unary(op)) data_addr <= addr_b;
              fb_step <= FB_LATCH_A;
            end
            FB_LATCH_A: begin
              opnd_a <= data_in;
              if (is_unary(op)) begin
                alu_in1    <= data_in;
                alu_in2    <= '0;
                alu_opcode <= op;
                state      <= EXEC;
              end else begin
                fb_step <= FB_LATCH_B;
              end
            end
            FB_LATCH_B: begin
              alu_in1    <= opnd_a;
              alu_in2    <= data_in;
              alu_opcode <= op;
              state      <= EXEC;
            end
            default: fb_step <= FB_LATCH_B;
          endcase
        end
        EXEC: begin
          result       <= alu_result;
          result_valid <= 1'b1;
          state        <= WB;
        end
        WB: begin
          // Dropping the opcode between instructions retriggers the ALU even
          // when consecutive opcodes are identical.
          alu_opcode <= '0;
          if (last_instr) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            pc      <= pc_next;
            op_addr <= pc_next;
            state   <= F_OP;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: sync ROM models, a reference ALU, and a program-level
// model that predicts result sequence, busy length and err for each run.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] prog_len;
  logic [3:0] op_addr;
  logic [7:0] op_data;
  logic [3:0] data_addr;
  logic [7:0] data_in;
  logic [7:0] alu_in1;
  logic [7:0] alu_in2;
  logic [7:0] alu_opcode;
  logic [7:0] alu_result;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad = 0;

`ifdef ALU_SEQ_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic [7:0] op_rom[16];
  logic [7:0] data_rom[16];

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] model_result;
  int         exp_busy;
  int         exp_rv;
  logic       exp_err;
  int         busy_n;
  int         rv_n;
  bit         addr2_seen;
  bit         addr2_watch = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
    .op_addr(op_addr), .op_data(op_data), .data_addr(data_addr), .data_in(data_in),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .result(result), .result_valid(result_valid),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] o, input logic [7:0] a,
                                       input logic [7:0] b);
    case (o)
      8'd1: return a + b;
      8'd2: return a - b;
      8'd3: return a & b;
      8'd4: return a | b;
      8'd5: return ~a;
      8'd6: return a << 1;
      8'd7: return (a < b) ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_in1, alu_in2);

  always @(posedge clk) begin
    op_data <= op_rom[op_addr];
    data_in <= data_rom[data_addr];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every result pulse is checked against the model queue; the ALU opcode must
  // be idle whenever the sequencer is not busy.
  always @(negedge clk) begin
    if (!rst) begin
      if (result_valid) begin
        got_q.push_back(result);
        if (exp_q.size() == 0) check("unexpected_result_valid", 32'(result), 32'hffff_ffff);
        else check("result", 32'(result), 32'(exp_q.pop_front()));
      end
      if (!busy) check("idle_alu_opcode", 32'(alu_opcode), 32'd0);
      if (addr2_watch && data_addr == 4'd2) addr2_seen = 1'b1;
    end
  end

  // Program-level model: what each instruction produces and how long it takes.
  task automatic build_expect(input int len);
    exp_q.delete();
    exp_busy = 1;
    exp_rv = 0;
    exp_err = 1'b0;
    for (int pc = 0; pc < len; pc++) begin
      logic [7:0] o, a, b;
      bit un, ch;
      o = op_rom[pc];
      if (o == 8'd0) begin
        exp_busy += 2;
        break;
      end
      if (o > 8'd7) begin
        exp_err = 1'b1;
        exp_busy += 2;
        continue;
      end
      un = (o == 8'd5) || (o == 8'd6);
      ch = CHAIN && (pc > 0);
      a = ch ? model_result : data_rom[(2 * pc) % 16];
      b = un ? 8'd0 : data_rom[(2 * pc + 1) % 16];
      model_result = alu_f(o, a, b);
      exp_q.push_back(model_result);
      exp_rv++;
      exp_busy += ch ? (un ? 4 : 6) : (un ? 6 : 7);
    end
  endtask

  task automatic run_prog(input int len, input bit inject);
    bit seen_done;
    build_expect(len);
    got_q.delete();
    @(negedge clk);
    start = 1'b1;
    prog_len = 4'(len);
    @(negedge clk);
    start = 1'b0;
    prog_len = 4'($urandom);
    busy_n = 0;
    rv_n = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy) busy_n++;
      if (result_valid) rv_n++;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      start = inject && (i == 1);
      if (start) prog_len = 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", 32'(seen_done), 32'd1);
    check("busy_cycles", 32'(busy_n), 32'(exp_busy));
    check("result_valid_count", 32'(rv_n), 32'(exp_rv));
    check("err", 32'(err), 32'(exp_err));
    check("results_left", 32'(exp_q.size()), 32'd0);
    check("result_reg", 32'(result), 32'(model_result));
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_pulse_width", 32'(done), 32'd0);
  endtask

  task automatic load_spec_roms();
    logic [7:0] ops[7];
    logic [7:0] dat[6];
    ops = '{8'h01, 8'h05, 8'h07, 8'h04, 8'h02, 8'h06, 8'h03};
    dat = '{8'h26, 8'hc7, 8'h9c, 8'h8c, 8'hbc, 8'h7e};
    for (int i = 0; i < 16; i++) begin
      op_rom[i] = (i < 7) ? ops[i] : 8'h01;
      data_rom[i] = (i < 6) ? dat[i] : 8'(i * 17);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    prog_len = 4'd0;
    model_result = 8'd0;
    load_spec_roms();
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {op_addr, data_addr, alu_in1, alu_in2}, 32'd0);
    check("reset_outputs2",
          {alu_opcode, result, 12'd0, result_valid, busy, done, err}, 32'd0);
    rst = 1'b0;

    run_prog(1, 1'b0);
    check("len1_result_literal", 32'(got_q.size() > 0 ? got_q[0] : 8'h00), 32'hed);
    check("len1_busy_literal", 32'(busy_n), 32'd8);

    run_prog(3, 1'b1);
`ifndef ALU_SEQ_CHAIN_EN
    check("len3_r0_literal", 32'(got_q.size() > 0 ? got_q[0] : 8'h00), 32'hed);
    check("len3_r1_literal", 32'(got_q.size() > 1 ? got_q[1] : 8'hff), 32'h63);
    check("len3_r2_literal", 32'(got_q.size() > 2 ? got_q[2] : 8'hff), 32'h00);
`endif
    check("len3_count_literal", 32'(rv_n), 32'd3);

    op_rom[2] = 8'h09;
    run_prog(3, 1'b0);
    check("err_count_literal", 32'(rv_n), 32'd2);
    check("err_set_literal", 32'(err), 32'd1);
    repeat (5) @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    op_rom[2] = 8'h07;

    run_prog(0, 1'b0);
    check("len0_busy_literal", 32'(busy_n), 32'd1);
    check("len0_rv_literal", 32'(rv_n), 32'd0);
    check("err_cleared_by_start", 32'(err), 32'd0);

    // Reset in the middle of the operand fetch of the first instruction.
    @(negedge clk);
    start = 1'b1;
    prog_len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrun_reset_a", {op_addr, data_addr, alu_in1, alu_in2}, 32'd0);
    check("midrun_reset_b",
          {alu_opcode, result, 12'd0, result_valid, busy, done, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_result = 8'd0;
    run_prog(1, 1'b0);
    check("after_reset_literal", 32'(result), 32'hed);

`ifdef ALU_SEQ_CHAIN_EN
    addr2_seen = 1'b0;
    addr2_watch = 1'b1;
    run_prog(2, 1'b0);
    addr2_watch = 1'b0;
    check("chain_r1_literal", 32'(got_q.size() > 1 ? got_q[1] : 8'h00), 32'h12);
    check("chain_no_addr2", 32'(addr2_seen), 32'd0);
`endif

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 16; i++) begin
        int r;
        r = $urandom_range(0, 19);
        op_rom[i] = (r < 17) ? 8'(1 + r % 7) : (r == 17) ? 8'h00 : 8'($urandom_range(8, 255));
        data_rom[i] = 8'($urandom);
      end
      run_prog($urandom_range(0, 15), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
